vram_port_arbiter: RTL and testbench

//  Shares one port of the single-port text-mode VRAM BRAM between two requesters.

---
 rtl/vram_port_arbiter_if.sv | 44 ++++
 rtl/vram_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_vram_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_port_arbiter_if.sv
// Bus bundle shared by the VRAM port arbiter, the scanout fetcher, the CPU slave and the BRAM port.
interface vram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;

    logic              cpu_req;
    logic              cpu_we;
    logic [BE_W-1:0]   cpu_be;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              bram_en;
    logic [BE_W-1:0]   bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;

    modport slave (
        input  disp_req, disp_addr,
        input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        input  bram_dout,
        output disp_rvalid, disp_rdata,
        output cpu_ack, cpu_rdata,
        output bram_en, bram_we, bram_addr, bram_din
    );

    modport master (
        output disp_req, disp_addr,
        output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        output bram_dout,
        input  disp_rvalid, disp_rdata,
        input  cpu_ack, cpu_rdata,
        input  bram_en, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Single BRAM port shared between a never-stalling scanout reader and a req/ack CPU slave.
// Optional `VRAM_ARB_STATS_EN adds conflict and worst-case CPU wait counters.
module vram_port_arbiter #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
) (
    input  logic               Clk,
    input  logic               reset_al,
    vram_port_arbiter_if.slave bus
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]        stat_conflicts,
    output logic [15:0]        stat_max_wait
`endif
);
    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, ACK} cpu_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CPU} owner_t;

    cpu_state_t        state;
    owner_t            tag_issue;
    owner_t            tag_data;
    logic              cpu_write;
    logic              disp_win;
    logic              cpu_win;

    logic              en_q;
    logic [BE_W-1:0]   we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              disp_rvalid_q;
    logic [DATA_W-1:0] disp_rdata_q;
    logic              cpu_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    always_comb begin
        disp_win = bus.disp_req;
        cpu_win  = bus.cpu_req && !bus.disp_req && (state == IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!reset_al) begin
            state         <= IDLE;
            tag_issue     <= OWN_NONE;
            tag_data      <= OWN_NONE;
            cpu_write     <= 1'b0;
            en_q          <= 1'b0;
            we_q          <= '0;
            addr_q        <= '0;
            din_q         <= '0;
            disp_rvalid_q <= 1'b0;
            disp_rdata_q  <= '0;
            cpu_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
        end else begin
            // Slot issue: winner of this cycle drives the BRAM next cycle.
            en_q <= disp_win || cpu_win;
            if (disp_win) begin
                we_q   <= '0;
                addr_q <= bus.disp_addr;
            end else if (cpu_win) begin
                we_q   <= bus.cpu_we ? bus.cpu_be : '0;
                addr_q <= bus.cpu_addr;
                din_q  <= bus.cpu_wdata;
            end else begin
                we_q <= '0;
            end

            // Owner tag follows the slot through the BRAM read latency.
            if (disp_win)
                tag_issue <= OWN_DISP;
            else if (cpu_win)
                tag_issue <= OWN_CPU;
            else
                tag_issue <= OWN_NONE;
            tag_data <= tag_issue;

            disp_rvalid_q <= (tag_data == OWN_DISP);
            if (tag_data == OWN_DISP)
                disp_rdata_q <= bus.bram_dout;

            cpu_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_win) begin
                        state     <= ISSUE;
                        cpu_write <= bus.cpu_we;
                    end
                end
                ISSUE: begin
                    if (cpu_write) begin
                        state     <= ACK;
                        cpu_ack_q <= 1'b1;
                    end else begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    state     <= ACK;
                    cpu_ack_q <= 1'b1;
                    if (tag_data == OWN_CPU)
                        cpu_rdata_q <= bus.bram_dout;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.bram_en     = en_q;
    assign bus.bram_we     = we_q;
    assign bus.bram_addr   = addr_q;
    assign bus.bram_din    = din_q;
    assign bus.disp_rvalid = disp_rvalid_q;
    assign bus.disp_rdata  = disp_rdata_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.cpu_rdata   = cpu_rdata_q;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] wait_cnt;

    always_ff @(posedge Clk) begin
        if (!reset_al) begin
            stat_conflicts <= '0;
            stat_max_wait  <= '0;
            wait_cnt       <= '0;
        end else begin
            if (bus.cpu_req && bus.disp_req && (state == IDLE) && (stat_conflicts != '1))
                stat_conflicts <= stat_conflicts + 16'd1;
            // wait_cnt counts blocked IDLE cycles of the pending request; folded in at the win.
            if (bus.cpu_req && (state == IDLE)) begin
                if (cpu_win) begin
                    wait_cnt <= '0;
                    if (wait_cnt > stat_max_wait)
                        stat_max_wait <= wait_cnt;
                end else if (wait_cnt != '1) begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: directed vector table, hand sequences and random traffic vs a slot-level model.
module tb_vram_port_arbiter;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;

    logic Clk = 1'b0;
    logic reset_al = 1'b0;
    always #5 Clk = ~Clk;

    vram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stat_conflicts;
    logic [15:0] stat_max_wait;
`endif

    vram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Clk      (Clk),
        .reset_al (reset_al),
        .bus      (bus)
`ifdef VRAM_ARB_STATS_EN
        ,
        .stat_conflicts (stat_conflicts),
        .stat_max_wait  (stat_max_wait)
`endif
    );

    // BRAM with one cycle read latency
    logic [31:0] vram [2048];
    always @(posedge Clk) begin
        if (bus.bram_en) begin
            for (int i = 0; i < 4; i++)
                if (bus.bram_we[i]) vram[bus.bram_addr][8*i +: 8] <= bus.bram_din[8*i +: 8];
            bus.bram_dout <= vram[bus.bram_addr];
        end
    end

    // Requester must hold its request stable until acknowledged
    logic        p_req = 1'b0, p_we;
    logic [3:0]  p_be;
    logic [10:0] p_addr;
    logic [31:0] p_wdata;
    always @(posedge Clk) begin
        if (reset_al && p_req && !bus.cpu_ack)
            assert (bus.cpu_req && bus.cpu_we == p_we && bus.cpu_be == p_be &&
                    bus.cpu_addr == p_addr && bus.cpu_wdata == p_wdata)
            else $error("cpu request inputs changed before ack");
        p_req   <= bus.cpu_req;
        p_we    <= bus.cpu_we;
        p_be    <= bus.cpu_be;
        p_addr  <= bus.cpu_addr;
        p_wdata <= bus.cpu_wdata;
    end

    // Reference model: slot decisions per cycle, expectations scheduled by due cycle
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rv_seen = 0;
    logic [31:0] ref_mem [2048];
    bit          sch_en [int];
    logic [3:0]  sch_we [int];
    logic [31:0] sch_rv [int];
    int          ack_due = -1;
    bit          ack_rd = 1'b0;
    logic [31:0] ack_data;
    int          avail = 0;
    int          zero_at = -1;
    int          cpu_start = 0;
    int          m_conf = 0;
    int          m_maxw = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_decide();
        int w;
        if (!reset_al) begin
            sch_en.delete();
            sch_we.delete();
            sch_rv.delete();
            ack_due = -1;
            avail   = cyc + 1;
            zero_at = cyc + 1;
            m_conf  = 0;
            m_maxw  = 0;
            return;
        end
        if (bus.disp_req) begin
            sch_en[cyc+1] = 1'b1;
            sch_rv[cyc+3] = ref_mem[bus.disp_addr];
            if (bus.cpu_req && cyc >= avail && m_conf < 65535) m_conf++;
        end else if (bus.cpu_req && cyc >= avail) begin
            sch_en[cyc+1] = 1'b1;
            w = cyc - cpu_start;
            if (w > 65535) w = 65535;
            if (w > m_maxw) m_maxw = w;
            if (bus.cpu_we) begin
                sch_we[cyc+1] = bus.cpu_be;
                for (int i = 0; i < 4; i++)
                    if (bus.cpu_be[i]) ref_mem[bus.cpu_addr][8*i +: 8] = bus.cpu_wdata[8*i +: 8];
                ack_due = cyc + 2;
                ack_rd  = 1'b0;
            end else begin
                ack_due  = cyc + 3;
                ack_rd   = 1'b1;
                ack_data = ref_mem[bus.cpu_addr];
            end
            avail = ack_due + 1;
        end
    endtask

    task automatic check_cycle();
        logic       e_rv, e_ack, e_en;
        logic [3:0] e_we;
        e_rv  = (sch_rv.exists(cyc) != 0);
        e_en  = (sch_en.exists(cyc) != 0);
        e_we  = (sch_we.exists(cyc) != 0) ? sch_we[cyc] : 4'h0;
        e_ack = (cyc == ack_due);
        check("ctl{rvalid,ack,en,we}",
              {25'h0, bus.disp_rvalid, bus.cpu_ack, bus.bram_en, bus.bram_we},
              {25'h0, e_rv, e_ack, e_en, e_we});
        if (e_rv) check("disp_rdata", bus.disp_rdata, sch_rv[cyc]);
        if (e_ack && ack_rd) check("cpu_rdata", bus.cpu_rdata, ack_data);
        if (cyc == zero_at)
            check("reset_data", bus.disp_rdata | bus.cpu_rdata | bus.bram_din | {21'h0, bus.bram_addr}, 32'h0);
        sch_rv.delete(cyc);
        sch_en.delete(cyc);
        sch_we.delete(cyc);
    endtask

    task automatic tick();
        model_decide();
        @(posedge Clk);
        #1;
        cyc++;
        check_cycle();
        if (bus.disp_rvalid) rv_seen++;
    endtask

    task automatic wait_ack(output int ack_cyc);
        ack_cyc = -1;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (bus.cpu_ack) begin
                ack_cyc = cyc;
                break;
            end
        end
        if (ack_cyc < 0) check("ack_timeout", {31'h0, bus.cpu_ack}, 32'h1);
        bus.cpu_req = 1'b0;
    endtask

    task automatic start_cpu(input logic we, input logic [3:0] be, input logic [10:0] addr,
                             input logic [31:0] wdata);
        bus.cpu_we    = we;
        bus.cpu_be    = be;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_req   = 1'b1;
        cpu_start     = cyc;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt [8];
        int   ack_c, t0, rv0;

        vt[0] = '{1'b1, 4'hF,    11'h012, 32'hDEADBEEF, 32'h0,        2};
        vt[1] = '{1'b0, 4'hF,    11'h012, 32'h0,        32'hDEADBEEF, 3};
        vt[2] = '{1'b1, 4'b0010, 11'h012, 32'h0000AB00, 32'h0,        2};
        vt[3] = '{1'b0, 4'h0,    11'h012, 32'h0,        32'hDEADABEF, 3};
        vt[4] = '{1'b1, 4'h0,    11'h012, 32'h12345678, 32'h0,        2};
        vt[5] = '{1'b0, 4'hF,    11'h012, 32'h0,        32'hDEADABEF, 3};
        vt[6] = '{1'b1, 4'b1001, 11'h7FF, 32'hA1B2C3D4, 32'h0,        2};
        vt[7] = '{1'b0, 4'h0,    11'h7FF, 32'h0,        32'hA1DE07D4, 3};

        for (int i = 0; i < 2048; i++) begin
            vram[i]    = 32'hC0DE0000 | i;
            ref_mem[i] = 32'hC0DE0000 | i;
        end
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_be    = '0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.bram_dout = '0;

        reset_al = 1'b0;
        repeat (3) tick();
        reset_al = 1'b1;
        tick();

        // Directed CPU transactions with fixed latencies and read-back values
        foreach (vt[i]) begin
            start_cpu(vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata);
            t0 = cyc;
            wait_ack(ack_c);
            check("tbl_latency", ack_c - t0, vt[i].lat);
            if (!vt[i].we) check("tbl_rdata", bus.cpu_rdata, vt[i].rdata);
            tick();
        end

        // 80-cycle scanout stream with a CPU read held off until it stops
        start_cpu(1'b0, 4'hF, 11'h012, 32'h0);
        rv0 = rv_seen;
        bus.disp_req = 1'b1;
        for (int k = 0; k < 80; k++) begin
            bus.disp_addr = 11'(k);
            tick();
        end
        bus.disp_req = 1'b0;
        t0 = cyc;
        wait_ack(ack_c);
        check("t3_ack_after_stream", ack_c - t0, 3);
        check("t3_cpu_rdata", bus.cpu_rdata, 32'hDEADABEF);
        check("t3_rvalid_count", rv_seen - rv0, 80);
`ifdef VRAM_ARB_STATS_EN
        check("t3_stat_conflicts", {16'h0, stat_conflicts}, m_conf);
        check("t3_stat_max_wait", {16'h0, stat_max_wait}, m_maxw);
`endif
        tick();

        // CPU read at t, scanout read at t+1: no cross-delivery
        start_cpu(1'b0, 4'hF, 11'h020, 32'h0);
        t0 = cyc;
        tick();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h021;
        tick();
        bus.disp_req = 1'b0;
        wait_ack(ack_c);
        check("t5_ack_latency", ack_c - t0, 3);
        check("t5_cpu_rdata", bus.cpu_rdata, 32'hC0DE0020);
        tick();
        check("t5_disp_rvalid", {31'h0, bus.disp_rvalid}, 32'h1);
        check("t5_disp_rdata", bus.disp_rdata, 32'hC0DE0021);
        tick();

        // Reset while a CPU read sits in RD_WAIT and a scanout read is in flight
        start_cpu(1'b0, 4'hF, 11'h030, 32'h0);
        tick();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h031;
        tick();
        bus.disp_req = 1'b0;
        bus.cpu_req  = 1'b0;
        reset_al     = 1'b0;
        tick();
        reset_al = 1'b1;
        rv0 = rv_seen;
        repeat (6) tick();
        check("t6_dropped_rvalid", rv_seen - rv0, 0);

        // Random traffic
        t0 = cyc;
        for (int k = 0; k < 1500; k++) begin
            bus.disp_req  = ($urandom_range(0, 99) < 45);
            bus.disp_addr = 11'($urandom_range(0, 31));
            if (!bus.cpu_req && $urandom_range(0, 3) == 0) begin
                start_cpu(1'($urandom_range(0, 1)), 4'($urandom), 11'($urandom_range(0, 31)), $urandom);
                t0 = cyc;
            end
            tick();
            if (bus.cpu_ack) begin
                bus.cpu_req = 1'b0;
            end else if (bus.cpu_req && (cyc - t0) > 400) begin
                check("rand_ack_timeout", {31'h0, bus.cpu_ack}, 32'h1);
                bus.cpu_req = 1'b0;
            end
        end
        bus.disp_req = 1'b0;
        if (bus.cpu_req) wait_ack(ack_c);
        repeat (6) tick();
`ifdef VRAM_ARB_STATS_EN
        check("final_stat_conflicts", {16'h0, stat_conflicts}, m_conf);
        check("final_stat_max_wait", {16'h0, stat_max_wait}, m_maxw);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
